// File: rtl/fpu_sched_pkg.sv
// Shared definitions for the FPU issue scheduler.
//   FPU_LAT     : issue-to-output latency of fpu_top (register stages)
//   FPU_OP_*    : operator encoding understood by fpu_top
//   fpu_tag_t   : {valid, id} tag carried alongside the fpu_top pipeline
package fpu_sched_pkg;

    localparam int FPU_LAT  = 5;
    localparam int TAG_ID_W = 8;

    localparam logic [1:0] FPU_OP_ADD = 2'd0;
    localparam logic [1:0] FPU_OP_SUB = 2'd1;
    localparam logic [1:0] FPU_OP_MUL = 2'd2;
    localparam logic [1:0] FPU_OP_DIV = 2'd3;

    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } fpu_tag_t;

endpackage

// File: rtl/fpu_rr_arb.sv
// Round-robin arbiter with advance-on-accept.
//   clk, rst  : clock, synchronous active-high reset (pointer -> 0)
//   req       : per-requester valid
//   credit_ok : gates the grant; the winner still gets selected when low
//   grant     : one-hot ready to the winner, or zero
//   gnt_idx   : index of the winner (pointer value when nobody requests)
//   accept    : handshake of the winner this cycle
// Handshake: a transfer happens in a cycle where req[i] and grant[i] are
// both high; the pointer then moves to the index after the winner.
module fpu_rr_arb #(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic            credit_ok,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  gnt_idx,
    output logic            accept
);

    logic [IDW-1:0] ptr;
    logic           found;
    int             idx;

    // Scan from ptr upwards, wrapping; the first requester found wins.
    always_comb begin
        found   = 1'b0;
        idx     = 0;
        gnt_idx = ptr;
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(ptr) + i) % NREQ;
            if (!found && req[idx]) begin
                found   = 1'b1;
                gnt_idx = IDW'(idx);
            end
        end
        grant = '0;
        if (found) grant[gnt_idx] = credit_ok;
    end

    assign accept = |(req & grant);

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (accept) begin
            ptr <= (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
        end
    end

endmodule

// File: rtl/fpu_top.sv
// Five-stage single-precision FPU: fetch, unpack, align, compute, normalize.
//   clk : clock (no reset, no stall, no valid -- callers tag their ops)
//   a,b : IEEE-754 single operands
//   op  : FPU_OP_ADD / SUB / MUL / DIV
//   out : result, valid five edges after the operands are presented
// Denormals flush to zero, rounding truncates, no NaN generation;
// overflow and x/0 give signed infinity.
module fpu_top
    import fpu_sched_pkg::*;
(
    input  logic        clk,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [1:0]  op,
    output logic [31:0] out
);

    // fetch
    logic [31:0] f_a, f_b;
    logic [1:0]  f_op;
    always_ff @(posedge clk) begin
        f_a  <= a;
        f_b  <= b;
        f_op <= op;
    end

    // unpack; for add/sub the larger magnitude goes to x so y only shifts right
    logic        sa, sb, swap;
    logic [7:0]  ea, eb;
    logic [23:0] ma, mb;
    always_comb begin
        sa   = f_a[31];
        sb   = f_b[31] ^ (f_op == FPU_OP_SUB);
        ea   = f_a[30:23];
        eb   = f_b[30:23];
        ma   = (ea == 8'd0) ? 24'd0 : {1'b1, f_a[22:0]};
        mb   = (eb == 8'd0) ? 24'd0 : {1'b1, f_b[22:0]};
        swap = ((f_op == FPU_OP_ADD) || (f_op == FPU_OP_SUB)) && ({eb, mb} > {ea, ma});
    end

    logic        u_sx, u_sy;
    logic [7:0]  u_ex, u_ey;
    logic [23:0] u_mx, u_my;
    logic [1:0]  u_op;
    always_ff @(posedge clk) begin
        u_sx <= swap ? sb : sa;
        u_sy <= swap ? sa : sb;
        u_ex <= swap ? eb : ea;
        u_ey <= swap ? ea : eb;
        u_mx <= swap ? mb : ma;
        u_my <= swap ? ma : mb;
        u_op <= f_op;
    end

    // align (three guard bits below the mantissa)
    logic [7:0]  diff;
    logic [26:0] my_al;
    always_comb begin
        diff  = u_ex - u_ey;
        my_al = {u_my, 3'b000};
        if ((u_op == FPU_OP_ADD) || (u_op == FPU_OP_SUB))
            my_al = (diff > 8'd26) ? 27'd0 : (my_al >> diff);
    end

    logic        al_sx, al_sy;
    logic [7:0]  al_ex, al_ey;
    logic [26:0] al_mx, al_my;
    logic [1:0]  al_op;
    always_ff @(posedge clk) begin
        al_sx <= u_sx;
        al_sy <= u_sy;
        al_ex <= u_ex;
        al_ey <= u_ey;
        al_mx <= {u_mx, 3'b000};
        al_my <= my_al;
        al_op <= u_op;
    end

    // compute; every result is scaled so that 1.0 sits at bit 46 of c_m_n
    logic [23:0]        cx, cy;
    logic [27:0]        sum;
    logic [47:0]        prod, quo;
    logic               c_s_n, c_inf_n;
    logic signed [10:0] c_e_n;
    logic [47:0]        c_m_n;
    always_comb begin
        cx      = al_mx[26:3];
        cy      = al_my[26:3];
        sum     = (al_sx ^ al_sy) ? ({1'b0, al_mx} - {1'b0, al_my})
                                  : ({1'b0, al_mx} + {1'b0, al_my});
        prod    = {24'd0, cx} * {24'd0, cy};
        quo     = (cy == 24'd0) ? 48'd0 : ({cx, 24'd0} / {24'd0, cy});
        c_s_n   = al_sx;
        c_inf_n = 1'b0;
        c_e_n   = $signed({3'b000, al_ex});
        c_m_n   = {sum, 20'd0};
        case (al_op)
            FPU_OP_MUL: begin
                c_s_n = al_sx ^ al_sy;
                c_e_n = $signed({3'b000, al_ex}) + $signed({3'b000, al_ey}) - 11'sd127;
                c_m_n = prod;
            end
            FPU_OP_DIV: begin
                c_s_n   = al_sx ^ al_sy;
                c_e_n   = $signed({3'b000, al_ex}) - $signed({3'b000, al_ey}) + 11'sd127;
                c_m_n   = quo << 22;
                c_inf_n = (cy == 24'd0) && (cx != 24'd0);
            end
            default: ;
        endcase
    end

    logic               c_s, c_inf;
    logic signed [10:0] c_e;
    logic [47:0]        c_m;
    always_ff @(posedge clk) begin
        c_s   <= c_s_n;
        c_inf <= c_inf_n;
        c_e   <= c_e_n;
        c_m   <= c_m_n;
    end

    // normalize
    logic [5:0]         lead;
    logic [47:0]        norm;
    logic signed [10:0] exp_n;
    always_comb begin
        lead = 6'd0;
        for (int i = 0; i < 48; i++)
            if (c_m[i]) lead = 6'(i);
        norm  = c_m << (6'd47 - lead);
        exp_n = c_e + $signed({5'd0, lead}) - 11'sd46;
    end

    logic unused_norm;
    assign unused_norm = &{1'b0, norm[47], norm[23:0]};

    always_ff @(posedge clk) begin
        if (c_inf || ((c_m != 48'd0) && (exp_n >= 11'sd255)))
            out <= {c_s, 8'hFF, 23'd0};
        else if ((c_m == 48'd0) || (exp_n <= 11'sd0))
            out <= 32'd0;
        else
            out <= {c_s, exp_n[7:0], norm[46:24]};
    end

endmodule

// File: rtl/fpu_issue_sched.sv
// Shares one fpu_top pipeline among NREQ requesters.
//   clk, rst        : clock, synchronous active-high reset
//   req_valid/ready : per-requester handshake (ready is one-hot or zero)
//   req_a/b/op      : packed operands, requester i at [32i+31:32i] / [2i+1:2i]
//   res_valid/ready : result FIFO head handshake
//   res_data/res_id : result and the requester index that issued it
//   busy            : ops in flight or results waiting
// Handshake: each valid/ready pair transfers on a clock edge where both are
// high; valid may be dropped freely before a transfer.
// Optional: define FPU_ISSUE_SCHED_STATS_EN to add stat_issued/stat_stall.
module fpu_issue_sched
    import fpu_sched_pkg::*;
#(
    parameter  int NREQ      = 4,
    parameter  int RES_DEPTH = 8,
    localparam int IDW       = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*32-1:0] req_a,
    input  logic [NREQ*32-1:0] req_b,
    input  logic [NREQ*2-1:0] req_op,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [31:0]       res_data,
    output logic [IDW-1:0]    res_id,
    output logic              busy
`ifdef FPU_ISSUE_SCHED_STATS_EN
    ,
    output logic [31:0]       stat_issued,
    output logic [31:0]       stat_stall
`endif
);

    localparam int PW = $clog2(RES_DEPTH);
    localparam int CW = $clog2(RES_DEPTH + 1);

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(RES_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    logic [IDW-1:0] gnt_idx;
    logic           accept, credit_ok;
    logic [CW-1:0]  inflight, fifo_count;
    logic [CW:0]    used;

    // A slot is reserved at accept, so the FIFO write can never overflow.
    // A same-cycle pop frees its slot only from the next cycle on.
    assign used      = {1'b0, inflight} + {1'b0, fifo_count};
    assign credit_ok = (used < (CW+1)'(RES_DEPTH));

    fpu_rr_arb #(.NREQ(NREQ)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (req_valid),
        .credit_ok (credit_ok),
        .grant     (req_ready),
        .gnt_idx   (gnt_idx),
        .accept    (accept)
    );

    logic [31:0] fpu_a, fpu_b, fpu_out;
    logic [1:0]  fpu_op;
    always_comb begin
        fpu_a  = req_a[32*int'(gnt_idx) +: 32];
        fpu_b  = req_b[32*int'(gnt_idx) +: 32];
        fpu_op = req_op[2*int'(gnt_idx) +: 2];
    end

    fpu_top u_fpu (
        .clk (clk),
        .a   (fpu_a),
        .b   (fpu_b),
        .op  (fpu_op),
        .out (fpu_out)
    );

    // Tag pipe runs in lockstep with fpu_top; only valid tags matter.
    fpu_tag_t tag_q [FPU_LAT];
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FPU_LAT; i++) tag_q[i] <= '0;
        end else begin
            tag_q[0] <= '{valid: accept, id: TAG_ID_W'(gnt_idx)};
            for (int i = 1; i < FPU_LAT; i++) tag_q[i] <= tag_q[i-1];
        end
    end

    logic unused_tag_bits;
    assign unused_tag_bits = &{1'b0, tag_q[FPU_LAT-1].id};

    logic           fifo_wr, pop;
    logic [31:0]    wr_data;
    logic [IDW-1:0] wr_id;
    logic [PW-1:0]  wr_ptr, rd_ptr, rd_ptr_nxt;
    logic [31:0]    mem_data [RES_DEPTH];
    logic [IDW-1:0] mem_id   [RES_DEPTH];

    assign fifo_wr    = tag_q[FPU_LAT-1].valid;
    assign wr_data    = fpu_out;
    assign wr_id      = tag_q[FPU_LAT-1].id[IDW-1:0];
    assign res_valid  = (fifo_count != '0);
    assign pop        = res_valid & res_ready;
    assign rd_ptr_nxt = ptr_inc(rd_ptr);
    assign busy       = (inflight != '0) || (fifo_count != '0);

    always_ff @(posedge clk) begin
        if (fifo_wr) begin
            mem_data[wr_ptr] <= wr_data;
            mem_id[wr_ptr]   <= wr_id;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            inflight   <= '0;
            res_data   <= '0;
            res_id     <= '0;
        end else begin
            if (fifo_wr) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)     rd_ptr <= rd_ptr_nxt;

            case ({fifo_wr, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: ;
            endcase

            case ({accept, fifo_wr})
                2'b10:   inflight <= inflight + CW'(1);
                2'b01:   inflight <= inflight - CW'(1);
                default: ;
            endcase

            // Head register: the incoming word becomes head when the FIFO
            // is (or is about to be) empty; otherwise the next stored entry
            // moves up on a pop. With nothing left it holds its last value.
            if (fifo_wr && ((fifo_count == '0) || (pop && (fifo_count == CW'(1))))) begin
                res_data <= wr_data;
                res_id   <= wr_id;
            end else if (pop && (fifo_count > CW'(1))) begin
                res_data <= mem_data[rd_ptr_nxt];
                res_id   <= mem_id[rd_ptr_nxt];
            end
        end
    end

`ifdef FPU_ISSUE_SCHED_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_issued <= '0;
            stat_stall  <= '0;
        end else begin
            if (accept && (stat_issued != '1))
                stat_issued <= stat_issued + 32'd1;
            if ((|req_valid) && !accept && (stat_stall != '1))
                stat_stall <= stat_stall + 32'd1;
        end
    end
`endif

endmodule
